// File: rtl/button_pkg.sv
// Shared types, width helper and 100 MHz board defaults for the push-button bank.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_DELAY   = 2'd2,
        ST_REPEAT  = 2'd3
    } btn_state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    localparam int             DEF_N_BTN        = 5;
    localparam int             DEF_TICK_DIV     = 100000;
    localparam int             DEF_DEB_LEN      = 8;
    localparam logic [4:0]     DEF_REPEAT_MASK  = 5'b11000;
    localparam int             DEF_REPEAT_DELAY = 500;
    localparam int             DEF_REPEAT_RATE  = 100;

endpackage

// File: rtl/btn_channel.sv
// One button channel: tick-sampled debounce, press pulse and optional hold-to-repeat.
// The FSM acts on the next debounced level so pulse, level and held all change on the same edge.
module btn_channel
    import button_pkg::*;
#(
    parameter int DEB_LEN      = DEF_DEB_LEN,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic s_i,
    input  logic rep_en,
    output logic level,
    output logic pulse,
    output logic held
);

    localparam int DEB_W   = clog2_min1(DEB_LEN);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = clog2_min1(REP_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_LEN - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic             level_nxt;
    btn_state_t       state, state_nxt;
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             pulse_nxt;

    // Any sample agreeing with the current level restarts the count.
    always_comb begin
        level_nxt   = level;
        deb_cnt_nxt = deb_cnt;
        if (tick) begin
            if (s_i == level) begin
                deb_cnt_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
                level_nxt   = ~level;
                deb_cnt_nxt = '0;
            end else begin
                deb_cnt_nxt = deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = rep_cnt;
        pulse_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level_nxt) begin
                    pulse_nxt   = 1'b1;
                    rep_cnt_nxt = '0;
                    state_nxt   = rep_en ? ST_DELAY : ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!level_nxt) state_nxt = ST_IDLE;
            end
            ST_DELAY: begin
                // Release takes priority over an expiring delay.
                if (!level_nxt) begin
                    state_nxt   = ST_IDLE;
                    rep_cnt_nxt = '0;
                end else if (tick) begin
                    if (rep_cnt == DELAY_LAST) begin
                        state_nxt   = ST_REPEAT;
                        pulse_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!level_nxt) begin
                    state_nxt   = ST_IDLE;
                    rep_cnt_nxt = '0;
                end else if (tick) begin
                    if (rep_cnt == RATE_LAST) begin
                        pulse_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                rep_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= 1'b0;
            deb_cnt <= '0;
            state   <= ST_IDLE;
            rep_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            level   <= level_nxt;
            deb_cnt <= deb_cnt_nxt;
            state   <= state_nxt;
            rep_cnt <= rep_cnt_nxt;
            pulse   <= pulse_nxt;
        end
    end

    assign held = (state == ST_REPEAT);

endmodule

// File: rtl/button_bank.sv
// N-channel push-button conditioner: shared tick divider, per-channel synchronisers
// and channels, plus a lowest-index-wins event encoder over the registered pulses.
module button_bank
    import button_pkg::*;
#(
    parameter int               N_BTN        = DEF_N_BTN,
    parameter int               TICK_DIV     = DEF_TICK_DIV,
    parameter int               DEB_LEN      = DEF_DEB_LEN,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = N_BTN'(DEF_REPEAT_MASK),
    parameter int               REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int               REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_in,
    output logic [N_BTN-1:0]         btn_level,
    output logic [N_BTN-1:0]         btn_pulse,
    output logic [N_BTN-1:0]         btn_held,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_multi
);

    localparam int                TICK_W    = clog2_min1(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int                ID_W      = $clog2(N_BTN);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [N_BTN-1:0]  sync_q1, sync_q2;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            sync_q1  <= '0;
            sync_q2  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            sync_q1  <= btn_in;
            sync_q2  <= sync_q1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEB_LEN      (DEB_LEN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .s_i    (sync_q2[i]),
            .rep_en (REPEAT_MASK[i]),
            .level  (btn_level[i]),
            .pulse  (btn_pulse[i]),
            .held   (btn_held[i])
        );
    end

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        evt_id = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn_pulse[i]) evt_id = ID_W'(i);
        end
    end

    assign evt_valid = |btn_pulse;
    assign evt_multi = |(btn_pulse & (btn_pulse - 1'b1));

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank with short timing; expected pulses (cycle and vector) are
// predicted from the tick phase and queued when each button is driven.
module tb_button_bank;

    localparam int               N_BTN        = 5;
    localparam int               TICK_DIV     = 4;
    localparam int               DEB_LEN      = 3;
    localparam int               REPEAT_DELAY = 5;
    localparam int               REPEAT_RATE  = 2;
    localparam logic [N_BTN-1:0] REPEAT_MASK  = 5'b11000;
    localparam int               ID_W         = $clog2(N_BTN);

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_held;
    logic             evt_valid;
    logic [ID_W-1:0]  evt_id;
    logic             evt_multi;

    int cyc     = 0;
    int r_base  = 0;
    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 1'b0;

    logic [N_BTN-1:0] exp_q[$];
    int               exp_t_q[$];
    logic [N_BTN-1:0] mon_v;

    button_bank #(
        .N_BTN        (N_BTN),
        .TICK_DIV     (TICK_DIV),
        .DEB_LEN      (DEB_LEN),
        .REPEAT_MASK  (REPEAT_MASK),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .btn_held  (btn_held),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_multi (evt_multi)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- timing model ----------------
    // Ticks occur on edges r_base+4k (k>=1) after the last reset edge.
    function automatic int tick_at_or_after(input int t);
        int u;
        u = (t < r_base + TICK_DIV) ? r_base + TICK_DIV : t;
        while (((u - r_base) % TICK_DIV) != 0) u++;
        return u;
    endfunction

    // Input changed at negedge c: synchronised value first sampled at edge c+3.
    function automatic int level_change(input int c);
        return tick_at_or_after(c + 3) + (DEB_LEN - 1) * TICK_DIV;
    endfunction

    function automatic logic [31:0] low_idx(input logic [N_BTN-1:0] v);
        for (int i = 0; i < N_BTN; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic push_exp(input int t, input logic [N_BTN-1:0] v);
        int i;
        i = 0;
        while (i < exp_t_q.size() && exp_t_q[i] < t) i++;
        if (i < exp_t_q.size() && exp_t_q[i] == t) begin
            exp_q[i] = exp_q[i] | v;
        end else begin
            exp_t_q.insert(i, t);
            exp_q.insert(i, v);
        end
    endtask

    task automatic schedule(input int ch, input int c_on, input int d_off,
                            output int p, output int t_f);
        logic [N_BTN-1:0] oh;
        int               r;
        oh = '0;
        oh[ch] = 1'b1;
        p   = level_change(c_on);
        t_f = level_change(d_off);
        push_exp(p, oh);
        if (REPEAT_MASK[ch]) begin
            r = p + REPEAT_DELAY * TICK_DIV;
            while (r < t_f) begin
                push_exp(r, oh);
                r += REPEAT_RATE * TICK_DIV;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
                mon_v = exp_q.pop_front();
                void'(exp_t_q.pop_front());
                check("missed_pulse", 32'(btn_pulse), 32'(mon_v));
            end
            if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
                mon_v = exp_q.pop_front();
                void'(exp_t_q.pop_front());
                check("pulse_vec", 32'(btn_pulse), 32'(mon_v));
                check("evt_valid", 32'(evt_valid), 32'd1);
                check("evt_id", 32'(evt_id), low_idx(mon_v));
                check("evt_multi", 32'(evt_multi), 32'($countones(mon_v) > 1));
            end else if (btn_pulse != '0) begin
                check("unexpected_pulse", 32'(btn_pulse), 32'd0);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(btn_level), 32'd0);
        check({tag, "_pulse"}, 32'(btn_pulse), 32'd0);
        check({tag, "_held"}, 32'(btn_held), 32'd0);
        check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_evt_id"}, 32'(evt_id), 32'd0);
        check({tag, "_evt_multi"}, 32'(evt_multi), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c, p, tf, p_pre, d;
        rst    = 1'b1;
        btn_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        r_base = cyc;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Clean press on a non-repeat channel.
        c = cyc;
        btn_in[0] = 1'b1;
        schedule(0, c, c + 200, p, tf);
        wait_until(p - 1);
        check("press0_level_before", 32'(btn_level[0]), 32'd0);
        wait_until(p);
        check("press0_level", 32'(btn_level[0]), 32'd1);
        check("press0_held", 32'(btn_held[0]), 32'd0);
        wait_until(c + 200);
        btn_in[0] = 1'b0;
        wait_until(tf - 1);
        check("rel0_level_before", 32'(btn_level[0]), 32'd1);
        wait_until(tf);
        check("rel0_level", 32'(btn_level[0]), 32'd0);
        wait_until(tf + 8);

        // Short glitch must be rejected.
        c = cyc + $urandom_range(0, 3);
        wait_until(c);
        btn_in[1] = 1'b1;
        wait_until(c + 6);
        btn_in[1] = 1'b0;
        wait_until(c + 40);
        check("glitch_level", 32'(btn_level[1]), 32'd0);

        // Auto-repeat held for 100 cycles.
        c = cyc;
        btn_in[3] = 1'b1;
        schedule(3, c, c + 100, p, tf);
        wait_until(p);
        check("rep3_held_press", 32'(btn_held[3]), 32'd0);
        wait_until(p + REPEAT_DELAY * TICK_DIV - 1);
        check("rep3_held_pre", 32'(btn_held[3]), 32'd0);
        wait_until(p + REPEAT_DELAY * TICK_DIV);
        check("rep3_held_first", 32'(btn_held[3]), 32'd1);
        wait_until(c + 100);
        btn_in[3] = 1'b0;
        wait_until(tf - 1);
        check("rep3_held_late", 32'(btn_held[3]), 32'd1);
        wait_until(tf);
        check("rep3_rel_held", 32'(btn_held[3]), 32'd0);
        check("rep3_rel_level", 32'(btn_level[3]), 32'd0);
        wait_until(tf + 20);

        // Simultaneous press on channels 2 and 4.
        c = cyc + $urandom_range(0, 3);
        wait_until(c);
        btn_in[2] = 1'b1;
        btn_in[4] = 1'b1;
        schedule(2, c, c + 40, p, tf);
        schedule(4, c, c + 40, p, tf);
        wait_until(p);
        check("sim_level", 32'(btn_level), 32'b10100);
        check("sim_evt_id", 32'(evt_id), 32'd2);
        check("sim_evt_multi", 32'(evt_multi), 32'd1);
        wait_until(c + 40);
        btn_in[2] = 1'b0;
        btn_in[4] = 1'b0;
        wait_until(tf + 8);
        check("sim_rel_level", 32'(btn_level), 32'd0);

        // Reset while channel 4 is repeating; the still-held button re-presses.
        c = cyc;
        btn_in[4] = 1'b1;
        p = level_change(c);
        push_exp(p, 5'b10000);
        push_exp(p + REPEAT_DELAY * TICK_DIV, 5'b10000);
        wait_until(p + REPEAT_DELAY * TICK_DIV + 2);
        check("rst4_held_before", 32'(btn_held[4]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst    = 1'b0;
        r_base = cyc;
        c      = cyc;
        schedule(4, c, c + 60, p, tf);
        wait_until(c + 10);
        check("rst4_level_early", 32'(btn_level[4]), 32'd0);
        wait_until(p);
        check("rst4_level_repress", 32'(btn_level[4]), 32'd1);
        wait_until(c + 60);
        btn_in[4] = 1'b0;
        wait_until(tf + 8);

        // Release lands on the tick where the second repeat would fire.
        c = cyc;
        btn_in[3] = 1'b1;
        p_pre = level_change(c);
        d = p_pre + (REPEAT_DELAY + REPEAT_RATE) * TICK_DIV - 11;
        schedule(3, c, d, p, tf);
        wait_until(d);
        btn_in[3] = 1'b0;
        wait_until(tf - 1);
        check("rvr_held_before", 32'(btn_held[3]), 32'd1);
        wait_until(tf);
        check("rvr_held", 32'(btn_held[3]), 32'd0);
        check("rvr_level", 32'(btn_level[3]), 32'd0);
        check("rvr_pulse", 32'(btn_pulse[3]), 32'd0);
        wait_until(tf + 20);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
- Parametrised N-channel push-button conditioner that replaces the per-button debounce/one-pulse pairs instantiated at top level.
- Per channel: 2-flop synchroniser, tick-sampled debounce and one-cycle press pulse.
- Channels enabled in a mask also get hold-to-repeat pulses, used for volume and menu scrolling.
- Feeds control with per-channel pulses plus a priority-encoded event for simple consumers.

Parameters:
- N_BTN, 5, number of button channels.
- TICK_DIV, 100000, clk cycles per debounce sample tick (1 ms at 100 MHz); minimum 2.
- DEB_LEN, 8, consecutive identical samples required to change the debounced level; minimum 1.
- REPEAT_MASK, 5'b11000, bit i=1 enables auto-repeat on channel i.
- REPEAT_DELAY, 500, ticks from press pulse to first repeat pulse; minimum 1.
- REPEAT_RATE, 100, ticks between subsequent repeat pulses; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- btn_in  input  N_BTN  raw asynchronous button levels, active-high.
- btn_level  output  N_BTN  debounced level.
- btn_pulse  output  N_BTN  one-clk pulse on press and on each auto-repeat.
- btn_held  output  N_BTN  high while a repeat-enabled channel is in REPEAT state.
- evt_valid  output  1  any btn_pulse bit high this cycle.
- evt_id  output  $clog2(N_BTN)  lowest index with btn_pulse high; 0 when evt_valid=0.
- evt_multi  output  1  two or more btn_pulse bits high this cycle.

Behaviour:
- Reset is synchronous, active-high. On rst: every output, both synchroniser stages, tick counter, debounce counters, repeat counters and channel FSMs go to 0/IDLE.
- Tick counter: counts 0..TICK_DIV-1. tick is high for one clk when the count equals TICK_DIV-1, then the count wraps to 0. tick is shared by all channels.
- Synchroniser: btn_in goes through two flops to give s_i. Debounce acts on s_i only.
- Debounce, evaluated only on tick:
  - If s_i == btn_level[i], clear deb_cnt.
  - Otherwise increment deb_cnt. When it reaches DEB_LEN-1, toggle btn_level[i] and clear deb_cnt.
  - Any sample agreeing with the current level restarts the count (glitch rejection).
- Latency: btn_in edge to btn_level change is between 2+(DEB_LEN-1)*TICK_DIV+1 and 2+DEB_LEN*TICK_DIV clk.
- Channel FSM (rep_cnt counts ticks):
  - IDLE: on the rising edge of btn_level, assert btn_pulse for exactly the next clk.
    - If REPEAT_MASK[i]=1: go to DELAY with rep_cnt=0.
    - Else: go to PRESSED.
  - PRESSED: wait for btn_level=0, then go to IDLE. No pulse on release.
  - DELAY: rep_cnt increments on tick. When rep_cnt reaches REPEAT_DELAY-1 on a tick, go to REPEAT, pulse one clk, clear rep_cnt.
  - REPEAT: btn_held=1. rep_cnt increments on tick. When rep_cnt reaches REPEAT_RATE-1 on a tick, pulse one clk and clear rep_cnt.
  - Release: btn_level=0 in DELAY or REPEAT returns the FSM to IDLE and clears rep_cnt and btn_held in the same cycle. Release wins over a simultaneous repeat expiry, so no pulse is emitted.
- btn_pulse is registered and never wider than 1 clk. Channels are fully independent; simultaneous presses give simultaneous pulses.
- evt_id/evt_valid/evt_multi are combinational from the registered btn_pulse, so they are aligned with it.
- Reset mid-press: the channel returns to IDLE with level 0. A button still held after reset is re-debounced and yields a fresh press pulse. This is intentional.
- Counter widths: $clog2 of the respective maximum, at least 1 bit. There is no overflow because each counter wraps or clears at its terminal value.

Decomposition:
- Shared package button_pkg holds:
  - channel state enum (IDLE, PRESSED, DELAY, REPEAT), 2 bits;
  - a clog2-min-1 width helper;
  - default timing constants for the 100 MHz board.
- Sub-module btn_channel holds one channel's debounce counter, FSM and rep_cnt.
  - Inputs: clk, rst, tick, s_i, rep_en.
  - Outputs: level, pulse, held.
- button_bank contains the tick divider, the synchronisers, a generate loop of btn_channel, and the priority encoder.

Test Plan:
- All tests use TICK_DIV=4, DEB_LEN=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BTN=5, REPEAT_MASK=5'b11000.
- Clean press: btn_in[0] high for 200 clk. Expect btn_level[0] high 11..14 clk after the edge, exactly one btn_pulse[0], btn_held[0]=0, evt_id=0.
- Glitch rejection: btn_in[1] high for 6 clk, then low. Expect btn_level[1] to stay 0 and no pulse.
- Auto-repeat: btn_in[3] held for 100 clk. Expect a press pulse, a first repeat 20 clk later (5 ticks), further repeats every 8 clk, btn_held[3]=1 from the first repeat, and no pulse after release.
- Simultaneous press: btn_in[2] and btn_in[4] rise in the same cycle. Expect both pulses in the same clk, evt_valid=1, evt_id=2, evt_multi=1.
- Reset mid-hold: in REPEAT on channel 4, assert rst for 1 clk. Expect all outputs 0 the next cycle. With btn_in still high, expect a new press pulse 11..14 clk after reset release.
- Release versus repeat: drop btn_in[3] so that btn_level falls on the tick where a repeat would fire. Expect no pulse and btn_held to clear in the same cycle.
